// File: rtl/vector_floating_point_compare_mask_unit.sv
// Vector floating-point compare unit producing a packed per-element mask.
// Handshakes: a beat moves on a rising edge where beat_valid && beat_ready;
// the mask is handed over on an edge where mask_valid && mask_ready.
// The producer may raise beat_valid at any time; beat_ready is high only in RUN.
// Once raised, mask_valid stays high, with mask and invalid_flag held, until mask_ready.
module vector_floating_point_compare_mask_unit #(
  parameter int MAX_ELEMENTS = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    bit_mode,
  input  logic [1:0]              compare_op,
  input  logic [6:0]              vl,
  input  logic                    beat_valid,
  output logic                    beat_ready,
  input  logic [63:0]             vs2,
  input  logic [63:0]             vs1,
  output logic [MAX_ELEMENTS-1:0] mask,
  output logic                    mask_valid,
  input  logic                    mask_ready,
  output logic                    invalid_flag,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    mode_q;
  logic [1:0]              op_q;
  logic [6:0]              vl_q;
  logic [7:0]              idx_q;
  logic [MAX_ELEMENTS-1:0] mask_q;
  logic [MAX_ELEMENTS-1:0] mask_d;
  logic                    inv_q;
  logic                    p_valid_q;
  logic [7:0]              p_idx_q;
  logic [1:0]              p_res_q;
  logic                    p_nv_q;

  // Returns {nv, result} for one element; 32-bit operands sit in a[31:0].
  function automatic logic [1:0] fp_cmp(input logic [63:0] a, input logic [63:0] b,
                                        input logic is32, input logic [1:0] op);
    logic        sa, sb, na, nb, qa, qb, both_zero, eq, lt, res, nv;
    logic [62:0] ma, mb;
    if (is32) begin
      sa = a[31];
      sb = b[31];
      ma = {32'd0, a[30:0]};
      mb = {32'd0, b[30:0]};
      na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      qa = a[22];
      qb = b[22];
    end else begin
      sa = a[63];
      sb = b[63];
      ma = a[62:0];
      mb = b[62:0];
      na = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
      nb = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
      qa = a[51];
      qb = b[51];
    end
    both_zero = (ma == 63'd0) && (mb == 63'd0);
    eq = both_zero || ((sa == sb) && (ma == mb));
    if (sa != sb) lt = sa && !both_zero;
    else if (!sa) lt = (ma < mb);
    else          lt = (ma > mb);
    if (na || nb) begin
      res = (op == 2'b01);
      nv  = op[1] | (na & ~qa) | (nb & ~qb);
    end else begin
      nv = 1'b0;
      case (op)
        2'b00:   res = eq;
        2'b01:   res = ~eq;
        2'b10:   res = lt;
        default: res = lt | eq;
      endcase
    end
    return {nv, res};
  endfunction

  logic       accept;
  logic       en0, en1;
  logic [1:0] c0, c1;
  logic [7:0] idx_next;
  logic [6:0] vl_clamp;

  assign accept   = beat_valid && (state_q == S_RUN);
  assign en0      = idx_q < {1'b0, vl_q};
  assign en1      = mode_q && ((idx_q + 8'd1) < {1'b0, vl_q});
  assign c0       = fp_cmp(mode_q ? {32'd0, vs2[31:0]} : vs2,
                           mode_q ? {32'd0, vs1[31:0]} : vs1, mode_q, op_q);
  assign c1       = fp_cmp({32'd0, vs2[63:32]}, {32'd0, vs1[63:32]}, 1'b1, op_q);
  assign idx_next = idx_q + (mode_q ? 8'd2 : 8'd1);
  assign vl_clamp = (int'(vl) > MAX_ELEMENTS) ? 7'(MAX_ELEMENTS) : vl;

  // Merge the registered compare results of the previous beat into the mask.
  always_comb begin
    mask_d = mask_q;
    for (int i = 0; i < MAX_ELEMENTS; i++) begin
      if (p_valid_q && p_res_q[0] && (p_idx_q == 8'(i))) mask_d[i] = 1'b1;
      if (p_valid_q && p_res_q[1] && ((p_idx_q + 8'd1) == 8'(i))) mask_d[i] = 1'b1;
    end
  end

  // Control FSM, one-stage compare pipeline and mask/flag accumulation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      op_q      <= 2'b00;
      vl_q      <= 7'd0;
      idx_q     <= 8'd0;
      mask_q    <= '0;
      inv_q     <= 1'b0;
      p_valid_q <= 1'b0;
      p_idx_q   <= 8'd0;
      p_res_q   <= 2'b00;
      p_nv_q    <= 1'b0;
    end else begin
      p_valid_q <= accept;
      p_idx_q   <= idx_q;
      p_res_q   <= {c1[0] & en1, c0[0] & en0};
      p_nv_q    <= (c0[1] & en0) | (c1[1] & en1);
      mask_q    <= mask_d;
      inv_q     <= inv_q | (p_valid_q & p_nv_q);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q  <= bit_mode;
            op_q    <= compare_op;
            vl_q    <= vl_clamp;
            idx_q   <= 8'd0;
            mask_q  <= '0;
            inv_q   <= 1'b0;
            state_q <= (vl_clamp == 7'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            idx_q <= idx_next;
            if (idx_next >= {1'b0, vl_q}) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: state_q <= S_DONE;
        default: if (mask_ready) state_q <= S_IDLE;
      endcase
    end
  end

  assign beat_ready   = (state_q == S_RUN);
  assign mask_valid   = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign mask         = mask_q;
  assign invalid_flag = inv_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_vector_floating_point_compare_mask_unit.sv
// Bench for the vector FP compare mask unit: directed cases plus randomized
// operations checked against a real-valued reference model.
module tb_vector_floating_point_compare_mask_unit;

  localparam int ME = 64;

  localparam logic [63:0] D_1   = 64'h3FF0000000000000;
  localparam logic [63:0] D_2   = 64'h4000000000000000;
  localparam logic [63:0] D_3   = 64'h4008000000000000;
  localparam logic [63:0] D_M1  = 64'hBFF0000000000000;
  localparam logic [63:0] D_M05 = 64'hBFE0000000000000;
  localparam logic [63:0] D_QN  = 64'h7FF8000000000000;
  localparam logic [63:0] D_SN  = 64'h7FF0000000000001;

  // clock / reset and DUT signals
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          bit_mode = 1'b0;
  logic [1:0]    compare_op = 2'b00;
  logic [6:0]    vl = 7'd0;
  logic          beat_valid = 1'b0;
  logic          beat_ready;
  logic [63:0]   vs2 = 64'd0;
  logic [63:0]   vs1 = 64'd0;
  logic [ME-1:0] mask;
  logic          mask_valid;
  logic          mask_ready = 1'b0;
  logic          invalid_flag;
  logic          busy;
  logic [1:0]    dbg_state;

  always #5 clock = ~clock;

  vector_floating_point_compare_mask_unit #(.MAX_ELEMENTS(ME)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .bit_mode(bit_mode),
    .compare_op(compare_op), .vl(vl), .beat_valid(beat_valid),
    .beat_ready(beat_ready), .vs2(vs2), .vs1(vs1), .mask(mask),
    .mask_valid(mask_valid), .mask_ready(mask_ready),
    .invalid_flag(invalid_flag), .busy(busy), .dbg_state(dbg_state)
  );

  int          n_vec = 0;
  int          n_miss = 0;
  logic [63:0] q2[$];
  logic [63:0] q1[$];
  logic [63:0] got_mask;
  logic        got_inv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real f32_to_real(input logic [31:0] x);
    real mag;
    int  e;
    e = int'(x[30:23]);
    if (e == 255)    mag = 1.0e300;
    else if (e == 0) mag = real'(x[22:0]) * (2.0 ** (-149));
    else             mag = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return x[31] ? -mag : mag;
  endfunction

  // {nv, result} for one element, a = vs2 element, b = vs1 element
  function automatic logic [1:0] ref_elem(input logic [63:0] a, input logic [63:0] b,
                                          input logic is32, input logic [1:0] op);
    logic an, bn, asn, bsn, r, nv;
    real  ra, rb;
    if (is32) begin
      an  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      bn  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      asn = an && !a[22];
      bsn = bn && !b[22];
      ra  = f32_to_real(a[31:0]);
      rb  = f32_to_real(b[31:0]);
    end else begin
      an  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
      bn  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
      asn = an && !a[51];
      bsn = bn && !b[51];
      ra  = an ? 0.0 : $bitstoreal(a);
      rb  = bn ? 0.0 : $bitstoreal(b);
    end
    if (an || bn) begin
      r  = (op == 2'd1);
      nv = (op >= 2'd2) || asn || bsn;
    end else begin
      nv = 1'b0;
      case (op)
        2'd0:    r = (ra == rb);
        2'd1:    r = (ra != rb);
        2'd2:    r = (ra < rb);
        default: r = (ra <= rb);
      endcase
    end
    return {nv, r};
  endfunction

  task automatic model(input logic m, input logic [1:0] op, input int vle,
                       output logic [63:0] em, output logic einv);
    logic [63:0] a, b;
    logic [1:0]  r;
    int          bt;
    em = 64'd0;
    einv = 1'b0;
    for (int e = 0; e < vle; e++) begin
      bt = m ? e / 2 : e;
      if (!m) begin
        a = q2[bt]; b = q1[bt];
      end else if (e % 2 == 0) begin
        a = {32'd0, q2[bt][31:0]}; b = {32'd0, q1[bt][31:0]};
      end else begin
        a = {32'd0, q2[bt][63:32]}; b = {32'd0, q1[bt][63:32]};
      end
      r = ref_elem(a, b, m, op);
      em[e] = r[0];
      einv = einv | r[1];
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] rand_fp(input logic is32);
    int   k;
    logic s;
    k = $urandom_range(0, 11);
    s = 1'($urandom_range(0, 1));
    if (is32) begin
      case (k)
        0:       return 64'd0;
        1:       return 64'h80000000;
        2:       return {32'd0, s, 31'h7F800000};
        3:       return {32'd0, s, 8'hFF, 1'b1, 22'($urandom)};
        4:       return {32'd0, s, 8'hFF, 1'b0, 22'($urandom) | 22'd1};
        5:       return {32'd0, s, 8'h00, 23'($urandom)};
        default: return {32'd0, s, 8'(125 + $urandom_range(0, 5)), 3'($urandom), 20'd0};
      endcase
    end else begin
      case (k)
        0:       return 64'd0;
        1:       return 64'h8000000000000000;
        2:       return {s, 63'h7FF0000000000000};
        3:       return {s, 11'h7FF, 1'b1, 51'({$urandom, $urandom})};
        4:       return {s, 11'h7FF, 1'b0, 51'({$urandom, $urandom}) | 51'd1};
        5:       return {s, 11'h000, 52'({$urandom, $urandom})};
        default: return {s, 11'(1021 + $urandom_range(0, 5)), 3'($urandom), 49'd0};
      endcase
    end
  endfunction

  function automatic logic [63:0] rand_pair_b(input logic [63:0] a, input logic is32);
    int k;
    k = $urandom_range(0, 3);
    if (k == 0) return a;
    if (k == 1) return is32 ? (a ^ 64'h80000000) : (a ^ 64'h8000000000000000);
    return rand_fp(is32);
  endfunction

  task automatic gen_beats(input logic m, input int nb);
    logic [63:0] a0, b0, a1, b1;
    q2.delete();
    q1.delete();
    for (int i = 0; i < nb; i++) begin
      a0 = rand_fp(m);
      b0 = rand_pair_b(a0, m);
      if (m) begin
        a1 = rand_fp(1'b1);
        b1 = rand_pair_b(a1, 1'b1);
        q2.push_back({a1[31:0], a0[31:0]});
        q1.push_back({b1[31:0], b0[31:0]});
      end else begin
        q2.push_back(a0);
        q1.push_back(b0);
      end
    end
  endtask

  // One full operation; called and returns at a falling edge.
  task automatic do_op(input logic m, input logic [1:0] op, input int vl_in,
                       input int gap, input int hold, input string tag);
    int          vle, nb, bi, last, extra, rdy, cyc;
    logic        done, bv, stable, einv;
    logic [63:0] em;
    vle = (vl_in > ME) ? ME : vl_in;
    nb  = m ? (vle + 1) / 2 : vle;
    model(m, op, vle, em, einv);
    start = 1'b1; bit_mode = m; compare_op = op; vl = 7'(vl_in);
    @(negedge clock);
    chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    start = 1'b0;
    bi = 0; last = -1; extra = 0; rdy = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 400) begin
      if (mask_valid) done = 1'b1;
      else begin
        if (beat_ready) rdy++;
        start      = 1'($urandom_range(0, 1));
        bit_mode   = 1'($urandom);
        compare_op = 2'($urandom);
        vl         = 7'($urandom);
        if (bi < nb) begin
          bv = ($urandom_range(0, 99) >= gap);
          vs2 = q2[bi];
          vs1 = q1[bi];
        end else begin
          bv = 1'($urandom_range(0, 1));
          vs2 = {$urandom, $urandom};
          vs1 = {$urandom, $urandom};
        end
        beat_valid = bv;
        if (bv && beat_ready) begin
          if (bi < nb) begin
            bi++;
            if (bi == nb) last = cyc;
          end else extra++;
        end
        @(negedge clock);
        cyc++;
      end
    end
    chk({tag, "_done_in_budget"}, 64'(done), 64'd1);
    chk({tag, "_extra_beats"}, 64'(extra), 64'd0);
    if (nb == 0) begin
      chk({tag, "_ready_cycles"}, 64'(rdy), 64'd0);
      chk({tag, "_done_latency"}, 64'(cyc), 64'd0);
    end else begin
      chk({tag, "_last_beat_to_valid"}, 64'(cyc - last), 64'd2);
    end
    got_mask = 64'(mask);
    got_inv  = invalid_flag;
    chk({tag, "_mask"}, got_mask, em);
    chk({tag, "_invalid"}, 64'(got_inv), 64'(einv));
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      beat_valid = 1'($urandom_range(0, 1));
      vs2 = {$urandom, $urandom};
      vs1 = {$urandom, $urandom};
      start = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (64'(mask) !== got_mask || mask_valid !== 1'b1 ||
          invalid_flag !== got_inv || beat_ready !== 1'b0) stable = 1'b0;
    end
    chk({tag, "_held_stable"}, 64'(stable), 64'd1);
    mask_ready = 1'b1; start = 1'b0; beat_valid = 1'b0;
    @(negedge clock);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_mask_valid"}, 64'(mask_valid), 64'd0);
    mask_ready = 1'b0;
  endtask

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic m;
    int   v;
    // reset state
    repeat (2) @(negedge clock);
    chk("reset_mask", 64'(mask), 64'd0);
    chk("reset_mask_valid", 64'(mask_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_beat_ready", 64'(beat_ready), 64'd0);
    chk("reset_invalid", 64'(invalid_flag), 64'd0);
    reset_n = 1'b1;

    // 64-bit LT, first start right after reset release
    q2 = '{D_1, D_3, D_M1};
    q1 = '{D_2, D_2, D_M05};
    do_op(1'b0, 2'd2, 3, 0, 0, "lt64");
    chk("lt64_const_mask", got_mask, 64'h5);
    chk("lt64_const_inv", 64'(got_inv), 64'd0);

    // 32-bit EQ with signed zeros, quiet NaN and odd tail
    q2 = '{{32'h80000000, 32'h00000000}, {32'h40A00000, 32'h7FC00000}};
    q1 = '{{32'h00000000, 32'h80000000}, {32'h40A00000, 32'h7FC00000}};
    do_op(1'b1, 2'd0, 3, 0, 2, "eq32");
    chk("eq32_const_mask", got_mask, 64'h3);
    chk("eq32_const_inv", 64'(got_inv), 64'd0);

    // signaling NaN with NE, then LE
    q2 = '{D_SN};
    q1 = '{D_1};
    do_op(1'b0, 2'd1, 1, 0, 0, "ne_snan");
    chk("ne_snan_const_mask", got_mask, 64'h1);
    chk("ne_snan_const_inv", 64'(got_inv), 64'd1);
    do_op(1'b0, 2'd3, 1, 0, 0, "le_snan");
    chk("le_snan_const_mask", got_mask, 64'h0);
    chk("le_snan_const_inv", 64'(got_inv), 64'd1);

    // zero-length vector
    q2.delete(); q1.delete();
    do_op(1'b0, 2'd1, 0, 0, 1, "vl0");
    chk("vl0_const_mask", got_mask, 64'h0);

    // gappy beats and a held-off consumer
    gen_beats(1'b1, 5);
    do_op(1'b1, 2'd3, 9, 50, 5, "backpressure");

    // oversize vl clamps to the mask width
    gen_beats(1'b0, ME);
    do_op(1'b0, 2'd2, 100, 10, 1, "clamp64");
    gen_beats(1'b1, ME / 2);
    do_op(1'b1, 2'd0, 127, 10, 1, "clamp32");

    // abort in RUN after two of four beats
    start = 1'b1; bit_mode = 1'b0; compare_op = 2'd2; vl = 7'd4;
    @(negedge clock);
    start = 1'b0;
    beat_valid = 1'b1; vs2 = D_1; vs1 = D_2;
    @(negedge clock);
    vs2 = D_QN; vs1 = D_1;
    @(negedge clock);
    beat_valid = 1'b0;
    chk("abort_pre_mask", 64'(mask), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_mask", 64'(mask), 64'd0);
    chk("abort_mask_valid", 64'(mask_valid), 64'd0);
    chk("abort_invalid", 64'(invalid_flag), 64'd0);
    chk("abort_beat_ready", 64'(beat_ready), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    @(negedge clock);
    chk("abort_held_invalid", 64'(invalid_flag), 64'd0);
    reset_n = 1'b1;
    q2 = '{D_3, D_1, D_1, D_1};
    q1 = '{D_2, D_2, D_2, D_2};
    do_op(1'b0, 2'd2, 4, 20, 0, "after_abort");
    chk("after_abort_const_mask", got_mask, 64'hE);
    chk("after_abort_const_inv", 64'(got_inv), 64'd0);

    // randomized operations
    for (int t = 0; t < 16; t++) begin
      m = 1'($urandom_range(0, 1));
      v = $urandom_range(0, 75);
      gen_beats(m, m ? ((v > ME ? ME : v) + 1) / 2 : (v > ME ? ME : v));
      do_op(m, 2'($urandom_range(0, 3)), v, $urandom_range(0, 50),
            $urandom_range(0, 3), $sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
